sram_port_arbiter: RTL

- Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester and the memory-stage data requester.
- Issues at most one SRAM access per cycle and routes the returned read data to the owner of the in-flight access.
- Generates the per-requester accept (addr_ok) and response (data_ok) handshakes that IF and MEM use to stall.
- Data side has priority; a bounded-streak rule guarantees fetch forward progress.

---
 rtl/sram_port_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//    Shares one single-port synchronous SRAM (1-cycle read latency) between
//    the instruction-fetch port and the memory-stage data port. Grants are
//    combinational in the request cycle. The response is routed to the owner
//    of the in-flight access in the following cycle. The data side has
//    priority, but a bounded streak counter forces an inst grant so that
//    fetch keeps making progress.
module sram_port_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,
   input  logic              inst_cancel,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [3:0]        data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,

   output logic              sram_en,
   output logic [3:0]        sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   // Streak threshold as a 4-bit value (legal range 1..15).
   localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RESP_INST = 2'd1,
      RESP_DATA = 2'd2
   } state_t;

   state_t     state_q,  state_d;
   logic [3:0] streak_q, streak_d;
   logic       wr_q,     wr_d;   // in-flight data access is a store

   logic       gnt_inst;
   logic       gnt_data;
   logic       inst_starved;

   // Grant selection: data first, unless the waiting fetch has seen
   // MAX_DATA_STREAK data grants in a row. Reset suppresses every grant
   // so the SRAM sees no access while reset is held.
   always_comb begin
      gnt_inst     = 1'b0;
      gnt_data     = 1'b0;
      inst_starved = inst_req && (streak_q == MAX_S);
      if (!reset) begin
         if (data_req && !inst_starved) begin
            gnt_data = 1'b1;
         end else if (inst_req) begin
            gnt_inst = 1'b1;
         end
      end
   end

   // Next-state, streak and in-flight access bookkeeping.
   always_comb begin
      state_d  = IDLE;
      streak_d = streak_q;
      wr_d     = 1'b0;

      if (gnt_inst) begin
         state_d = RESP_INST;
      end else if (gnt_data) begin
         state_d = RESP_DATA;
         wr_d    = data_wr;
      end

      if (!inst_req || gnt_inst) begin
         streak_d = '0;
      end else if (gnt_data && (streak_q != MAX_S)) begin
         streak_d = streak_q + 4'd1;
      end
   end

   // SRAM request side: drive the granted requester's access, else idle zeros.
   always_comb begin
      sram_en      = 1'b0;
      sram_we      = '0;
      sram_addr    = '0;
      sram_wdata   = '0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;

      if (gnt_inst) begin
         sram_en      = 1'b1;
         sram_addr    = inst_addr;
         inst_addr_ok = 1'b1;
      end else if (gnt_data) begin
         sram_en      = 1'b1;
         sram_we      = data_wr ? data_wstrb : 4'b0000;
         sram_addr    = data_addr;
         sram_wdata   = data_wdata;
         data_addr_ok = 1'b1;
      end
   end

   // Response side: route the returned word to the owner of the access made
   // in the previous cycle. A flush in the response cycle drops a pending
   // fetch response. A fetch accepted in that same cycle is the redirected
   // fetch, and its own response in the next cycle is kept.
   always_comb begin
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_data_ok = 1'b0;
      data_rdata   = '0;

      if (!reset) begin
         if (state_q == RESP_INST && !inst_cancel) begin
            inst_data_ok = 1'b1;
            inst_rdata   = sram_rdata;
         end
         if (state_q == RESP_DATA) begin
            data_data_ok = 1'b1;
            data_rdata   = wr_q ? 32'h0 : sram_rdata;
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         streak_q <= '0;
         wr_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         wr_q     <= wr_d;
      end
   end

endmodule
